// File: rtl/pipeline_hazard_ctrl.sv
// Register scoreboard that stalls or flushes ID; optional macro HAZARD_FWD_EN tracks only loads.
// Outputs are combinational from the ID fields and the scoreboard; state and counters update each edge.
// The ID instruction is held while any source is pending, and an EX redirect flushes it.
module pipeline_hazard_ctrl #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_ID,
  input  logic [4:0]       Rs1_addr_ID,
  input  logic [4:0]       Rs2_addr_ID,
  input  logic             Rs1_used_ID,
  input  logic             Rs2_used_ID,
  input  logic [4:0]       Rd_addr_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             Branch_taken_EX,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             issue_ID,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0]       r_pend [32];
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_hazard;
  logic             w_mark;
  logic [1:0]       w_mark_val;

  assign w_rs1_hit = Rs1_used_ID && (Rs1_addr_ID != 5'd0) && (r_pend[Rs1_addr_ID] != 2'd0);
  assign w_rs2_hit = Rs2_used_ID && (Rs2_addr_ID != 5'd0) && (r_pend[Rs2_addr_ID] != 2'd0);
  assign w_hazard  = valid_ID && (w_rs1_hit || w_rs2_hit);

  assign issue_ID    = valid_ID & ~w_hazard & ~Branch_taken_EX;
  // The branch in EX is older than ID, so its flush wins over a stall.
  assign PC_stall    = w_hazard & ~Branch_taken_EX;
  assign IF_ID_stall = PC_stall;
  assign IF_ID_flush = Branch_taken_EX;
  assign ID_EX_flush = Branch_taken_EX | w_hazard;

`ifdef HAZARD_FWD_EN
  // Forwarding covers ALU results; only a load's data arrives too late for the next instruction.
  assign w_mark     = issue_ID & RegWrite_ID & MemRead_ID;
  assign w_mark_val = 2'd1;
`else
  logic w_unused;
  assign w_unused   = MemRead_ID;
  assign w_mark     = issue_ID & RegWrite_ID;
  assign w_mark_val = WB_LAT[1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        r_pend[r] <= 2'd0;
      end
    end else begin
      r_pend[0] <= 2'd0;
      for (int r = 1; r < 32; r++) begin
        if (w_mark && (Rd_addr_ID == 5'(r))) begin
          r_pend[r] <= w_mark_val;
        end else if (r_pend[r] != 2'd0) begin
          r_pend[r] <= r_pend[r] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (PC_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (Branch_taken_EX && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations follow HAZARD_FWD_EN when defined.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
`ifdef HAZARD_FWD_EN
  localparam int ALU_ST = 0;
  localparam int LD_ST  = 1;
`else
  localparam int ALU_ST = 3;
  localparam int LD_ST  = 3;
`endif

  logic             clk;
  logic             rst;
  logic             valid_ID;
  logic [4:0]       Rs1_addr_ID;
  logic [4:0]       Rs2_addr_ID;
  logic             Rs1_used_ID;
  logic             Rs2_used_ID;
  logic [4:0]       Rd_addr_ID;
  logic             RegWrite_ID;
  logic             MemRead_ID;
  logic             Branch_taken_EX;
  logic             PC_stall;
  logic             IF_ID_stall;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             issue_ID;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int tests;
  int fails;
  int exp_stall;
  int exp_flush;

  pipeline_hazard_ctrl #(.WB_LAT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_ID(valid_ID),
    .Rs1_addr_ID(Rs1_addr_ID), .Rs2_addr_ID(Rs2_addr_ID),
    .Rs1_used_ID(Rs1_used_ID), .Rs2_used_ID(Rs2_used_ID),
    .Rd_addr_ID(Rd_addr_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .Branch_taken_EX(Branch_taken_EX),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .issue_ID(issue_ID),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    valid_ID    = v;
    Rs1_addr_ID = rs1;
    Rs1_used_ID = u1;
    Rs2_addr_ID = rs2;
    Rs2_used_ID = u2;
    Rd_addr_ID  = rd;
    RegWrite_ID = rw;
    MemRead_ID  = mr;
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (4) tick();
  endtask

  // Producer writes rd=p, consumer reads p on both sources; expects exp_st stalls then issue.
  task automatic dep_seq(input string tag, input logic is_load, input logic [4:0] p, input int exp_st);
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, p, 1'b1, is_load);
    chk({tag, "_prod_issue"}, 32'(issue_ID), 32'd1);
    tick();
    set_id(1'b1, p, 1'b1, p, 1'b1, 5'd20, 1'b1, 1'b0);
    for (int c = 0; c <= exp_st; c++) begin
      chk($sformatf("%s_stall_c%0d", tag, c), 32'(PC_stall), 32'(c < exp_st));
      chk($sformatf("%s_ifid_stall_c%0d", tag, c), 32'(IF_ID_stall), 32'(c < exp_st));
      chk($sformatf("%s_issue_c%0d", tag, c), 32'(issue_ID), 32'(c == exp_st));
      tick();
    end
    exp_stall += exp_st;
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_stall = 0;
    exp_flush = 0;
    rst = 1'b0;
    Branch_taken_EX = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #3;
    chk("rst_pc_stall", 32'(PC_stall), 32'd0);
    chk("rst_idex_flush", 32'(ID_EX_flush), 32'd0);
    chk("rst_ifid_flush", 32'(IF_ID_flush), 32'd0);
    chk("rst_issue", 32'(issue_ID), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // add x5,x1,x2 ; sub x6,x5,x3
    dep_seq("alu_alu", 1'b0, 5'd5, ALU_ST);
    // lw x7,0(x0) ; add x8,x7,x7
    dep_seq("load_use", 1'b1, 5'd7, LD_ST);

    // addi x0,x0,1 ; add x1,x0,x0
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("x0_wr_issue", 32'(issue_ID), 32'd1);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    chk("x0_rd_stall", 32'(PC_stall), 32'd0);
    chk("x0_rd_issue", 32'(issue_ID), 32'd1);
    tick();
    chk("x0_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    drain();

    // Two writers to x9 two cycles apart: reader waits on the second.
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b0, 1'b0);
    chk("x9_unrel_issue", 32'(issue_ID), 32'd1);
    tick();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    chk("x9_w2_issue", 32'(issue_ID), 32'd1);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    for (int c = 0; c <= LD_ST; c++) begin
      chk($sformatf("x9_stall_c%0d", c), 32'(PC_stall), 32'(c < LD_ST));
      chk($sformatf("x9_issue_c%0d", c), 32'(issue_ID), 32'(c == LD_ST));
      tick();
    end
    exp_stall += LD_ST;
    chk("x9_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    drain();

    // Hazard on x5 coincides with a taken branch in EX.
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("br_pre_stall", 32'(PC_stall), 32'd1);
    Branch_taken_EX = 1'b1;
    #1;
    chk("br_pc_stall", 32'(PC_stall), 32'd0);
    chk("br_ifid_stall", 32'(IF_ID_stall), 32'd0);
    chk("br_ifid_flush", 32'(IF_ID_flush), 32'd1);
    chk("br_idex_flush", 32'(ID_EX_flush), 32'd1);
    chk("br_issue", 32'(issue_ID), 32'd0);
    tick();
    Branch_taken_EX = 1'b0;
    exp_flush += 1;
    chk("br_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    chk("br_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    drain();

    // Reset asserted while the consumer of x5 is stalled.
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
`ifndef HAZARD_FWD_EN
    tick();
`endif
    chk("rstmid_pre_stall", 32'(PC_stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_pc_stall", 32'(PC_stall), 32'd0);
    chk("rstmid_idex_flush", 32'(ID_EX_flush), 32'd0);
    chk("rstmid_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rstmid_flush_cnt", 32'(flush_cnt), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("rstrel_issue", 32'(issue_ID), 32'd1);
    chk("rstrel_pc_stall", 32'(PC_stall), 32'd0);
    tick();
    chk("rstrel_stall_cnt", 32'(stall_cnt), 32'd0);
    drain();

    // Flush counter saturates at all-ones.
    Branch_taken_EX = 1'b1;
    repeat (20) tick();
    Branch_taken_EX = 1'b0;
    #1;
    chk("flush_sat", 32'(flush_cnt), 32'((1 << CNT_W) - 1));
    tick();
    chk("flush_sat_hold", 32'(flush_cnt), 32'((1 << CNT_W) - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Scoreboard-based hazard and stall/flush controller for the 5-stage pipelined RV32I core.
- Sits beside the ID stage and tracks in-flight writes to each architectural register.
- Stalls the instruction in ID when it reads a register that is still pending, and inserts a bubble into ID/EX.
- Flushes IF/ID and ID/EX when EX resolves a taken branch or jump. Also keeps saturating stall and flush event counters for debug display.

Parameters:
- WB_LAT, 3: cycles after issue before a written register becomes readable in ID; range 1..3.
- CNT_W, 32: width of the stall and flush event counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_ID  in  1  ID holds a real instruction.
- Rs1_addr_ID  in  5  source register 1 (Inst[19:15]).
- Rs2_addr_ID  in  5  source register 2 (Inst[24:20]).
- Rs1_used_ID  in  1  the instruction reads rs1.
- Rs2_used_ID  in  1  the instruction reads rs2.
- Rd_addr_ID  in  5  destination register (Inst[11:7]).
- RegWrite_ID  in  1  the instruction writes rd.
- MemRead_ID  in  1  the instruction is a load.
- Branch_taken_EX  in  1  EX is redirecting the PC this cycle (taken branch, jal or jalr).
- PC_stall  out  1  hold the PC.
- IF_ID_stall  out  1  hold the IF/ID register.
- IF_ID_flush  out  1  load a NOP into IF/ID.
- ID_EX_flush  out  1  load a bubble into ID/EX.
- issue_ID  out  1  the ID instruction advances to EX this cycle.
- stall_cnt  out  CNT_W  total hazard stall cycles.
- flush_cnt  out  CNT_W  total flush events.

Behaviour:
- Scoreboard state: pend[1..31], each 2 bits. x0 is never tracked and always reads as not pending.
- hazard (combinational) is true when valid_ID is high and at least one of these holds:
  - Rs1_used_ID is high, Rs1_addr_ID != 0, and pend[Rs1_addr_ID] != 0.
  - Rs2_used_ID is high, Rs2_addr_ID != 0, and pend[Rs2_addr_ID] != 0.
- Output and issue equations (all combinational):
  - issue_ID = valid_ID & ~hazard & ~Branch_taken_EX.
  - PC_stall = IF_ID_stall = hazard & ~Branch_taken_EX. A flush overrides a stall because the branch in EX is older than the instruction in ID.
  - IF_ID_flush = Branch_taken_EX.
  - ID_EX_flush = Branch_taken_EX | hazard.
- Each rising edge, for every r in 1..31:
  - If issue_ID & RegWrite_ID & (Rd_addr_ID == r): pend[r] <= WB_LAT. A new issue overrides the decrement, and a re-issue to the same rd restarts the count.
  - Otherwise, if pend[r] != 0: pend[r] <= pend[r] - 1.
- Latency without forwarding: a back-to-back dependent instruction stalls exactly WB_LAT cycles. With WB_LAT=3 the producer issues at cycle t, the consumer stalls in t+1..t+3 and issues at t+4.
- A flushed ID instruction never updates the scoreboard. Entries for instructions already in EX/MEM/WB keep counting down, because those instructions still retire.
- Counters, updated each edge and saturating at all-ones (no wrap):
  - stall_cnt increments when PC_stall is high.
  - flush_cnt increments when Branch_taken_EX is high.
- Reset, asynchronous and active at any time including mid-stall:
  - All pend entries, stall_cnt and flush_cnt go to 0.
  - The combinational outputs follow from the cleared state: with Branch_taken_EX=0, all stall and flush outputs are 0 and issue_ID = valid_ID.
- When valid_ID=0 there is no hazard, no issue and no scoreboard write; countdowns continue.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined (the core has an EX/MEM/WB forwarding network):
  - Only loads are tracked: on issue with MemRead_ID & RegWrite_ID, pend[rd] <= 1.
  - Non-load writes are never marked.
  - Load-use back-to-back costs 1 stall cycle; ALU-to-ALU dependences cost 0.
- Undefined: full scoreboard with WB_LAT, as specified under Behaviour.

Test Plan:
- Reset, then issue "add x5,x1,x2" followed by "sub x6,x5,x3" (WB_LAT=3, no macro) -> PC_stall=1 for exactly 3 cycles, sub issues on the 4th cycle, stall_cnt=3.
- Issue "lw x7,0(x0)" then "add x8,x7,x7" with HAZARD_FWD_EN defined -> exactly 1 stall cycle, stall_cnt=1. The same sequence with add as the producer -> 0 stalls.
- Issue "addi x0,x0,1" then "add x1,x0,x0" -> no stall; pend never set.
- Hazard stall active on x5 while Branch_taken_EX=1 in the same cycle -> PC_stall=0, IF_ID_flush=1, ID_EX_flush=1, issue_ID=0, flush_cnt increments by 1, stall_cnt unchanged.
- Two writers to x9, two cycles apart, then a reader -> the reader waits for the second writer: pend[x9] restarted to 3 at the second issue.
- Assert rst=0 mid-stall with pend[x5]=2 -> on release all outputs are 0, the consumer issues immediately, and both counters read 0.
